// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: ALU operation codes, operand-select encodings
// and positions of the decoded control bits.
package riscv_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLL  = 5'b00010;
  localparam logic [4:0] ALU_SLT  = 5'b00011;
  localparam logic [4:0] ALU_SLTU = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_OR   = 5'b01000;
  localparam logic [4:0] ALU_AND  = 5'b01001;
  localparam logic [4:0] ALU_LUI  = 5'b01010;
  localparam logic [4:0] ALU_BEQ  = 5'b01011;
  localparam logic [4:0] ALU_BNE  = 5'b01100;
  localparam logic [4:0] ALU_BLT  = 5'b01101;
  localparam logic [4:0] ALU_BGE  = 5'b01110;
  localparam logic [4:0] ALU_BLTU = 5'b01111;
  localparam logic [4:0] ALU_BGEU = 5'b10000;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'b00,
    SRC_A_PC   = 2'b01,
    SRC_A_ZERO = 2'b10,
    SRC_A_RSV  = 2'b11
  } src_a_e;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_e;

  // Bit positions inside the 5-bit {reg_write, mem_read, mem_write, branch, jump} bundle
  localparam int CTRL_REG_WRITE = 4;
  localparam int CTRL_MEM_READ  = 3;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_BRANCH    = 1;
  localparam int CTRL_JUMP      = 0;

endpackage

// File: rtl/fwd_mux.sv
// Per-source operand forwarding: picks MEM result, WB result or the held
// regfile value. MEM is younger and wins; loads in MEM cannot forward yet.
module fwd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic                  mem_reg_write,
  input  logic                  mem_is_load,
  input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_reg_write,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  always_comb begin
    fwd_data = rs_data;
    if (rs_addr != '0) begin
      if (mem_reg_write && !mem_is_load && (mem_rd_addr == rs_addr)) begin
        fwd_data = mem_result;
      end else if (wb_reg_write && (wb_rd_addr == rs_addr)) begin
        fwd_data = wb_result;
      end
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register plus operand select feeding the ALU combinationally, with
// MEM/WB forwarding, a single load-use bubble, back-pressure and flush.
module ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [4:0]            id_alu_ctrl,
  input  logic [1:0]            id_src_a,
  input  logic                  id_src_b,
  input  logic [4:0]            id_ctrl,
  input  logic                  mem_reg_write,
  input  logic                  mem_is_load,
  input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_reg_write,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [DATA_WIDTH-1:0] wb_result,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [4:0]            alu_ctrl,
  output logic [DATA_WIDTH-1:0] ex_store_data,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [ADDR_WIDTH-1:0] ex_rd_addr,
  output logic [4:0]            ex_ctrl,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [ADDR_WIDTH-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [4:0]            alu_ctrl_q, ctrl_q;
  src_a_e                src_a_q;
  src_b_e                src_b_q;
  logic [CNT_WIDTH-1:0]  stall_count_q;

  logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd;
  logic                  rs1_used, load_use, ex_fire, capture;

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs1 (
    .rs_addr(rs1_addr_q), .rs_data(rs1_data_q),
    .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .fwd_data(rs1_fwd)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs2 (
    .rs_addr(rs2_addr_q), .rs_data(rs2_data_q),
    .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .fwd_data(rs2_fwd)
  );

  // rs2 always counts as used because stores need it as data
  assign rs1_used = (src_a_q == SRC_A_RS1) || (src_a_q == SRC_A_RSV);
  assign load_use = valid_q && mem_reg_write && mem_is_load && (mem_rd_addr != '0) &&
                    ((rs1_used && (mem_rd_addr == rs1_addr_q)) || (mem_rd_addr == rs2_addr_q));

  assign ex_valid = valid_q && !load_use;
  assign ex_fire  = ex_valid && ex_ready;
  assign id_ready = !valid_q || ex_fire;
  assign capture  = id_valid && id_ready && !flush;

  always_comb begin
    alu_op1 = rs1_fwd;
    case (src_a_q)
      SRC_A_PC:   alu_op1 = pc_q;
      SRC_A_ZERO: alu_op1 = '0;
      default:    alu_op1 = rs1_fwd;
    endcase
  end

  assign alu_op2       = (src_b_q == SRC_B_IMM) ? imm_q : rs2_fwd;
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_store_data = rs2_fwd;
  assign ex_pc         = pc_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_ctrl       = ctrl_q;
  assign stall_count   = stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rd_addr_q     <= '0;
      alu_ctrl_q    <= '0;
      ctrl_q        <= '0;
      src_a_q       <= SRC_A_RS1;
      src_b_q       <= SRC_B_RS2;
      stall_count_q <= '0;
    end else begin
      if (load_use && !flush && (stall_count_q != '1)) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
      if (flush) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q    <= 1'b1;
        pc_q       <= id_pc;
        rs1_data_q <= id_rs1_data;
        rs2_data_q <= id_rs2_data;
        imm_q      <= id_imm;
        rs1_addr_q <= id_rs1_addr;
        rs2_addr_q <= id_rs2_addr;
        rd_addr_q  <= id_rd_addr;
        alu_ctrl_q <= id_alu_ctrl;
        ctrl_q     <= id_ctrl;
        src_a_q    <= src_a_e'(id_src_a);
        src_b_q    <= src_b_e'(id_src_b);
      end else if (ex_fire) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed hazard scenarios followed by random
// traffic, all checked against a behavioural model of the held instruction.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_ctrl, id_ctrl;
  logic [1:0]  id_src_a;
  logic        id_src_b;
  logic        mem_reg_write, mem_is_load, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic        flush, ex_ready, ex_valid;
  logic [31:0] alu_op1, alu_op2, ex_store_data, ex_pc, stall_count;
  logic [4:0]  alu_ctrl, ex_rd_addr, ex_ctrl;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_ctrl(id_alu_ctrl), .id_src_a(id_src_a), .id_src_b(id_src_b), .id_ctrl(id_ctrl),
    .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .mem_rd_addr(mem_rd_addr),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_result(wb_result), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
  );

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd, alu, ctrl;
    logic [1:0]  sa;
    logic        sb;
  } instr_t;

  instr_t      m;
  bit          m_valid;
  logic [31:0] m_cnt;
  bit          e_lu, e_exv, e_idr;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] held);
    if (a == 0) return held;
    if (mem_reg_write && !mem_is_load && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return held;
  endfunction

  task automatic model_compare();
    logic [31:0] e_op1, e_op2;
    bit rs1_needed;
    rs1_needed = (m.sa == 2'd0) || (m.sa == 2'd3);
    e_lu  = m_valid && mem_reg_write && mem_is_load && mem_rd_addr != 0 &&
            ((rs1_needed && mem_rd_addr == m.rs1) || mem_rd_addr == m.rs2);
    e_exv = m_valid && !e_lu;
    e_idr = !m_valid || (e_exv && ex_ready);
    e_op1 = (m.sa == 2'd1) ? m.pc : (m.sa == 2'd2) ? 32'd0 : fwd(m.rs1, m.rs1d);
    e_op2 = m.sb ? m.imm : fwd(m.rs2, m.rs2d);
    check("ex_valid", ex_valid, e_exv);
    check("id_ready", id_ready, e_idr);
    check("alu_op1", alu_op1, e_op1);
    check("alu_op2", alu_op2, e_op2);
    check("alu_ctrl", alu_ctrl, m.alu);
    check("store_data", ex_store_data, fwd(m.rs2, m.rs2d));
    check("ex_pc", ex_pc, m.pc);
    check("ex_rd", ex_rd_addr, m.rd);
    check("ex_ctrl", ex_ctrl, m.ctrl);
    check("stall_count", stall_count, m_cnt);
  endtask

  task automatic model_update();
    if (rst) begin
      m = '{default: '0};
      m_valid = 0;
      m_cnt = 0;
    end else begin
      if (e_lu && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (flush) m_valid = 0;
      else if (id_valid && e_idr) begin
        m = '{pc: id_pc, rs1d: id_rs1_data, rs2d: id_rs2_data, imm: id_imm,
              rs1: id_rs1_addr, rs2: id_rs2_addr, rd: id_rd_addr, alu: id_alu_ctrl,
              ctrl: id_ctrl, sa: id_src_a, sb: id_src_b};
        m_valid = 1;
      end else if (e_exv && ex_ready) m_valid = 0;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    #1;
    if (!rst) model_compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic zero_in();
    rst = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_ctrl = 0; id_ctrl = 0;
    id_src_a = 0; id_src_b = 0; mem_reg_write = 0; mem_is_load = 0; mem_rd_addr = 0;
    mem_result = 0; wb_reg_write = 0; wb_rd_addr = 0; wb_result = 0; flush = 0; ex_ready = 1;
  endtask

  task automatic rand_in();
    rst = ($urandom_range(0, 99) == 0);
    id_valid = ($urandom_range(0, 3) != 0);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
    id_rd_addr = 5'($urandom_range(0, 31)); id_alu_ctrl = 5'($urandom_range(0, 16));
    id_ctrl = 5'($urandom); id_src_a = 2'($urandom); id_src_b = 1'($urandom);
    mem_reg_write = 1'($urandom); mem_is_load = ($urandom_range(0, 2) == 0);
    mem_rd_addr = 5'($urandom_range(0, 7)); mem_result = $urandom;
    wb_reg_write = 1'($urandom); wb_rd_addr = 5'($urandom_range(0, 7)); wb_result = $urandom;
    flush = ($urandom_range(0, 15) == 0);
    ex_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    zero_in();
    rst = 1;
    m = '{default: '0}; m_valid = 0; m_cnt = 0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 0;
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_op1", alu_op1, 0);
    check("rst_op2", alu_op2, 0);
    check("rst_id_ready", id_ready, 1);
    check("rst_stall", stall_count, 0);
    cycle();

    // operand select
    id_valid = 1; id_pc = 32'h100; id_src_a = 2'b01; id_src_b = 1; id_imm = 32'hFFFF_FFFC;
    cycle();
    id_valid = 0; ex_ready = 0;
    #1;
    check("sel_op1", alu_op1, 32'h100);
    check("sel_op2", alu_op2, 32'hFFFF_FFFC);
    check("sel_valid", ex_valid, 1);
    cycle();

    // forwarding priority
    zero_in();
    id_valid = 1; id_rs1_addr = 5; id_rs1_data = 32'h55;
    cycle();
    id_valid = 0; ex_ready = 0;
    mem_reg_write = 1; mem_rd_addr = 5; mem_result = 32'h11;
    wb_reg_write = 1; wb_rd_addr = 5; wb_result = 32'h22;
    #1 check("fwd_mem", alu_op1, 32'h11);
    cycle();
    mem_reg_write = 0;
    #1 check("fwd_wb", alu_op1, 32'h22);
    cycle();
    ex_ready = 1; id_valid = 1; id_rs1_addr = 0; id_rs1_data = 32'h77;
    mem_reg_write = 1; mem_rd_addr = 0; wb_rd_addr = 0;
    cycle();
    id_valid = 0; ex_ready = 0;
    #1 check("fwd_x0", alu_op1, 32'h77);
    cycle();

    // load-use bubble
    zero_in();
    id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 7; id_rs2_data = 32'h1234;
    cycle();
    id_valid = 0; mem_reg_write = 1; mem_is_load = 1; mem_rd_addr = 7;
    #1;
    check("lu_valid", ex_valid, 0);
    check("lu_id_ready", id_ready, 0);
    cycle();
    mem_reg_write = 0; mem_is_load = 0; wb_reg_write = 1; wb_rd_addr = 7; wb_result = 32'hABCD;
    #1;
    check("lu_stall_count", stall_count, 1);
    check("lu_store_data", ex_store_data, 32'hABCD);
    check("lu_valid_after", ex_valid, 1);
    cycle();

    // back-pressure
    zero_in();
    id_valid = 1; id_pc = 32'h200; id_rd_addr = 3;
    cycle();
    ex_ready = 0; id_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_id_ready", id_ready, 0);
      check("bp_pc_stable", ex_pc, 32'h200);
      cycle();
    end
    ex_ready = 1;
    #1 check("bp_release", id_ready, 1);
    cycle();
    id_valid = 0; ex_ready = 0;
    #1 check("bp_next_pc", ex_pc, 32'h300);

    // flush beats capture
    id_valid = 1; id_pc = 32'h400; flush = 1; ex_ready = 0;
    cycle();
    flush = 0; id_valid = 0;
    #1;
    check("flush_valid", ex_valid, 0);
    check("flush_no_capture", ex_pc, 32'h300);
    cycle();

    for (int i = 0; i < 3000; i++) begin
      rand_in();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
